// File: rtl/hdb3_pkg.sv
// Shared symbol, pulse and mode encodings for the HDB3/AMI polarity path.
package hdb3_pkg;

  // Symbols arriving from the substitution encoder.
  localparam logic [1:0] SYM_ZERO = 2'b00;
  localparam logic [1:0] SYM_B    = 2'b01;
  localparam logic [1:0] SYM_BS   = 2'b10;
  localparam logic [1:0] SYM_V    = 2'b11;

  // Ternary pulse codes toward the line driver; 2'b10 is never produced.
  localparam logic [1:0] PUL_ZERO = 2'b00;
  localparam logic [1:0] PUL_POS  = 2'b01;
  localparam logic [1:0] PUL_NEG  = 2'b11;

  localparam logic MODE_HDB3 = 1'b0;
  localparam logic MODE_AMI  = 1'b1;

endpackage

// File: rtl/hdb3_polarity_lane.sv
// One channel of the polarity assigner: alternate-mark / violation polarity,
// saturating running disparity and a sticky coding-violation flag.
module hdb3_polarity_lane
  import hdb3_pkg::*;
#(
  parameter int DISP_W   = 4,
  parameter int DISP_LIM = 2,
  parameter bit INIT_NEG = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [1:0]        sym,
  input  logic              mode,
  input  logic              clear_err,
  output logic [1:0]        pulse,
  output logic [DISP_W-1:0] disp,
  output logic              err
);

  localparam logic signed [DISP_W-1:0] DISP_MAX = DISP_W'(2**(DISP_W-1) - 1);
  localparam logic signed [DISP_W-1:0] DISP_MIN = -DISP_MAX;
  localparam logic signed [DISP_W-1:0] LIM      = DISP_W'(DISP_LIM);
  localparam logic signed [DISP_W-1:0] ONE      = DISP_W'(1);

  // Polarity flags: 1 = negative pulse.
  logic                     last_pol, last_v_pol;
  logic                     err_q;
  logic [1:0]               pulse_q;
  logic signed [DISP_W-1:0] disp_q;

  logic                     last_pol_d, last_v_pol_d;
  logic [1:0]               pulse_d;
  logic signed [DISP_W-1:0] disp_d;
  logic                     mark, pol_neg, viol;

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    mark         = 1'b0;
    pol_neg      = last_pol;
    viol         = 1'b0;
    last_pol_d   = last_pol;
    last_v_pol_d = last_v_pol;

    case (sym)
      SYM_B, SYM_BS: begin
        mark       = 1'b1;
        pol_neg    = ~last_pol;
        last_pol_d = ~last_pol;
      end
      SYM_V: begin
        mark = 1'b1;
        if (mode == MODE_AMI) begin
          // V is illegal in AMI: send it as an ordinary alternating mark.
          pol_neg    = ~last_pol;
          last_pol_d = ~last_pol;
          viol       = 1'b1;
        end else begin
          // A V repeating the previous V's polarity means the substitution parity broke.
          pol_neg      = last_pol;
          viol         = (last_pol == last_v_pol);
          last_v_pol_d = last_pol;
        end
      end
      default: ;
    endcase

    disp_d = disp_q;
    if (mark) begin
      if (pol_neg) begin
        if (disp_q != DISP_MIN) disp_d = disp_q - ONE;
      end else begin
        if (disp_q != DISP_MAX) disp_d = disp_q + ONE;
      end
    end
    viol = viol || (disp_d > LIM) || (disp_d < -LIM);

    if (!mark)        pulse_d = PUL_ZERO;
    else if (pol_neg) pulse_d = PUL_NEG;
    else              pulse_d = PUL_POS;
  end

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
    if (!rst_n) begin
      last_pol   <= INIT_NEG;
      last_v_pol <= INIT_NEG;
      pulse_q    <= PUL_ZERO;
      disp_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      if (in_valid) begin
        last_pol   <= last_pol_d;
        last_v_pol <= last_v_pol_d;
        pulse_q    <= pulse_d;
        disp_q     <= disp_d;
      end
      // A new violation outranks a simultaneous clear.
      if (in_valid && viol) err_q <= 1'b1;
      else if (clear_err)   err_q <= 1'b0;
    end
  end

  assign pulse = pulse_q;
  assign disp  = disp_q;
  assign err   = err_q;

endmodule

// File: rtl/hdb3_polarity_mc.sv
// Multi-channel HDB3/AMI polarity assigner: NCH independent lanes sharing
// one valid strobe, with a one-cycle registered output.
module hdb3_polarity_mc
  import hdb3_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int DISP_W   = 4,
  parameter int DISP_LIM = 2,
  parameter bit INIT_NEG = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [2*NCH-1:0]      sym_in,
  input  logic [NCH-1:0]        mode,
  input  logic                  clear_err,
  output logic                  out_valid,
  output logic [2*NCH-1:0]      sym_out,
  output logic [DISP_W*NCH-1:0] disp,
  output logic [NCH-1:0]        err
);

  always_ff @(posedge clk) begin
    if (!rst_n) out_valid <= 1'b0;
    else        out_valid <= in_valid;
  end

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    hdb3_polarity_lane #(
      .DISP_W   (DISP_W),
      .DISP_LIM (DISP_LIM),
      .INIT_NEG (INIT_NEG)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .sym       (sym_in[2*k +: 2]),
      .mode      (mode[k]),
      .clear_err (clear_err),
      .pulse     (sym_out[2*k +: 2]),
      .disp      (disp[DISP_W*k +: DISP_W]),
      .err       (err[k])
    );
  end

endmodule

// File: tb/tb_hdb3_polarity_mc.sv
// Self-checking bench for hdb3_polarity_mc: table-driven vectors through a
// scoreboard queue, plus saturation and INIT_NEG=0 sequences.
module tb_hdb3_polarity_mc;

  typedef struct packed {
    logic        ov;
    logic [7:0]  so;
    logic [15:0] dp;
    logic [3:0]  er;
  } exp_t;

  typedef struct packed {
    logic       rst;
    logic       iv;
    logic [7:0] sym;
    logic [3:0] md;
    logic       clr;
    exp_t       exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  sym_in;
  logic [3:0]  mode;
  logic        clear_err;
  logic        out_valid;
  logic [7:0]  sym_out;
  logic [15:0] disp;
  logic [3:0]  err;

  // Second instance with the opposite reset polarity, one channel.
  logic        iv_p;
  logic [1:0]  sym_p;
  logic        ov_p;
  logic [1:0]  so_p;
  logic [3:0]  dp_p;
  logic        er_p;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  vec_t tbl[16];

  always #5 clk = ~clk;

  hdb3_polarity_mc #(.NCH(4), .DISP_W(4), .DISP_LIM(2), .INIT_NEG(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .sym_in(sym_in), .mode(mode),
    .clear_err(clear_err), .out_valid(out_valid), .sym_out(sym_out), .disp(disp), .err(err)
  );

  hdb3_polarity_mc #(.NCH(1), .DISP_W(4), .DISP_LIM(2), .INIT_NEG(1'b0)) dut_p (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_p), .sym_in(sym_p), .mode(1'b0),
    .clear_err(1'b0), .out_valid(ov_p), .sym_out(so_p), .disp(dp_p), .err(er_p)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic compare_pending(input string tag);
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, ".out_valid"}, 32'(out_valid), 32'(e.ov));
      check({tag, ".sym_out"},   32'(sym_out),   32'(e.so));
      check({tag, ".disp"},      32'(disp),      32'(e.dp));
      check({tag, ".err"},       32'(err),       32'(e.er));
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    compare_pending(tag);
    rst_n     = v.rst;
    in_valid  = v.iv;
    sym_in    = v.sym;
    mode      = v.md;
    clear_err = v.clr;
    sb.push_back(v.exp);
  endtask

  function automatic vec_t mk(input logic rst, input logic iv, input logic [7:0] sym,
                              input logic clr, input logic ov, input logic [7:0] so,
                              input logic [15:0] dp, input logic [3:0] er);
    vec_t v;
    v.rst = rst; v.iv = iv; v.sym = sym; v.md = 4'b0010; v.clr = clr;
    v.exp.ov = ov; v.exp.so = so; v.exp.dp = dp; v.exp.er = er;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    rst_n = 1'b0; in_valid = 1'b0; sym_in = '0; mode = 4'b0010; clear_err = 1'b0;
    iv_p = 1'b0; sym_p = 2'b00;

    // ch0 HDB3 B,0,0,V,B',0,0,V; ch1 AMI B,B,B,B,V; ch2 HDB3 V,0,0,0,V; ch3 HDB3 B,V,B,V.
    tbl[0]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 4'b0000);
    tbl[1]  = mk(1, 1, 8'h75, 0, 1, 8'h75, 16'h1F11, 4'b0100);
    tbl[2]  = mk(1, 1, 8'hC4, 0, 1, 8'h4C, 16'h2F01, 4'b0100);
    tbl[3]  = mk(1, 1, 8'h44, 0, 1, 8'hC4, 16'h1F11, 4'b0100);
    tbl[4]  = mk(1, 1, 8'hC7, 0, 1, 8'hCD, 16'h0F02, 4'b0100);
    tbl[5]  = mk(1, 1, 8'h3E, 0, 1, 8'h37, 16'h0E11, 4'b0110);
    tbl[6]  = mk(1, 1, 8'h00, 0, 1, 8'h00, 16'h0E11, 4'b0110);
    tbl[7]  = mk(1, 1, 8'h00, 0, 1, 8'h00, 16'h0E11, 4'b0110);
    tbl[8]  = mk(1, 1, 8'h03, 0, 1, 8'h03, 16'h0E10, 4'b0110);
    // Clear while idle; symbols ignored, output held.
    tbl[9]  = mk(1, 0, 8'hFF, 1, 0, 8'h03, 16'h0E10, 4'b0000);
    // Gap pattern B, x, B on ch0.
    tbl[10] = mk(1, 1, 8'h01, 0, 1, 8'h01, 16'h0E11, 4'b0000);
    tbl[11] = mk(1, 0, 8'h01, 0, 0, 8'h01, 16'h0E11, 4'b0000);
    tbl[12] = mk(1, 1, 8'h01, 0, 1, 8'h03, 16'h0E10, 4'b0000);
    // AMI V on ch1 together with clear_err: set wins.
    tbl[13] = mk(1, 1, 8'h0C, 1, 1, 8'h0C, 16'h0E00, 4'b0010);
    // Mid-stream reset overrides valid and clear, then first B goes positive.
    tbl[14] = mk(0, 1, 8'h55, 1, 0, 8'h00, 16'h0000, 4'b0000);
    tbl[15] = mk(1, 1, 8'h01, 0, 1, 8'h01, 16'h0001, 4'b0000);

    for (int i = 0; i < 16; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // ch3 HDB3: B then repeated V pushes disparity up to +7 and holds it there.
    apply(mk(0, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 4'b0000), "sat_rst");
    for (int i = 0; i < 9; i++) begin
      int d;
      d = (i + 1 > 7) ? 7 : i + 1;
      v = mk(1, 1, (i == 0) ? 8'h40 : 8'hC0, 0, 1, 8'h40,
             16'(d) << 12, (i >= 2) ? 4'b1000 : 4'b0000);
      v.md = 4'b0000;
      apply(v, $sformatf("sat%0d", i));
    end
    @(negedge clk);
    compare_pending("flush");
    in_valid = 1'b0;

    // INIT_NEG=0 instance: three B marks start negative.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("p_reset.sym_out", 32'(so_p), 32'h0);
    iv_p = 1'b1; sym_p = 2'b01;
    @(negedge clk);
    check("p_b0.sym_out", 32'(so_p), 32'h3);
    check("p_b0.disp",    32'(dp_p), 32'hF);
    @(negedge clk);
    check("p_b1.sym_out", 32'(so_p), 32'h1);
    check("p_b1.disp",    32'(dp_p), 32'h0);
    @(negedge clk);
    check("p_b2.sym_out", 32'(so_p), 32'h3);
    check("p_b2.valid",   32'(ov_p), 32'h1);
    check("p_b2.err",     32'(er_p), 32'h0);
    iv_p = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
